// File: rtl/fifo_collect.sv
// fifo_collect: serial-in/parallel-out collector that drops SKIP leading samples,
// then shifts DEPTH samples into q (q[0] = first) and holds them until clr/rst.
module fifo_collect #(
    parameter int DEPTH = 8,
    parameter int BITS  = 8,
    parameter int SKIP  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [BITS-1:0] d,
    output logic signed [BITS-1:0] q [DEPTH],
    output logic                   valid,
    output logic                   overrun
);
    localparam int MX = (SKIP > DEPTH) ? SKIP : DEPTH;
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] SKIP_LAST  = CW'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [CW-1:0] DEPTH_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {SKIP_ST, FILL_ST, DONE_ST} state_t;
    localparam state_t INIT = (SKIP == 0) ? FILL_ST : SKIP_ST;

    state_t                 r_state, w_state;
    logic [CW-1:0]          r_cnt, w_cnt;
    logic signed [BITS-1:0] r_q [DEPTH];
    logic                   r_valid, r_ovr;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        if (clr) begin
            w_state = INIT;
            w_cnt   = '0;
        end else if (en && r_state == SKIP_ST) begin
            w_state = (r_cnt == SKIP_LAST) ? FILL_ST : SKIP_ST;
            w_cnt   = (r_cnt == SKIP_LAST) ? '0 : r_cnt + 1'b1;
        end else if (en && r_state == FILL_ST) begin
            w_state = (r_cnt == DEPTH_LAST) ? DONE_ST : FILL_ST;
            w_cnt   = (r_cnt == DEPTH_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_valid <= (w_state == DONE_ST);
            r_ovr   <= clr ? 1'b0 : (r_ovr | (en && r_state == DONE_ST));
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            end else if (en && r_state == FILL_ST) begin
                // shift toward index 0 so the first collected sample lands in q[0]
                for (int i = 0; i < DEPTH - 1; i++) r_q[i] <= r_q[i+1];
                r_q[DEPTH-1] <= d;
            end
        end
    end

    assign q       = r_q;
    assign valid   = r_valid;
    assign overrun = r_ovr;
endmodule
